// File: rtl/vco_dec_pkg.sv
// vco_dec_pkg: register map, STATUS bit indices, FSM states and reset constants for the VCO ADC decimator
package vco_dec_pkg;
  localparam logic [7:0] OFF_CTRL = 8'h00;
  localparam logic [7:0] OFF_WIN = 8'h04;
  localparam logic [7:0] OFF_STATUS = 8'h08;
  localparam logic [7:0] OFF_DATA = 8'h0C;
  localparam logic [7:0] OFF_IRQ = 8'h10;
  localparam int ST_OVF = 8;
  localparam int ST_EMPTY = 9;
  localparam int ST_FULL = 10;
  localparam logic [15:0] WIN_RST = 16'd1000;
  localparam logic [7:0] IRQ_THR_RST = 8'd1;
  typedef enum logic [1:0] {IDLE, SETTLE, RUN} state_t;
  function automatic logic [15:0] win_eff(input logic [15:0] w);
    return (w == 16'd0) ? 16'd1 : w;
  endfunction
endpackage

// File: rtl/vco_dec_fifo.sv
// vco_dec_fifo: synchronous sample FIFO with push/pop/flush, level and full/empty flags
module vco_dec_fifo #(
  parameter int W = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = level == (AW+1)'(DEPTH);
  assign empty = level == '0;
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata = mem[rp];
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else begin
      wp <= wp + AW'(do_push);
      rp <= rp + AW'(do_pop);
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wp] <= wdata;
  end
endmodule

// File: rtl/vco_adc_decimator.sv
// vco_adc_decimator: VCO ADC edge-count decimator with sample FIFO and Wishbone regs; VCO_DEC_IRQ_EN adds IRQ_THR at 0x10 and drives irq_o
module vco_adc_decimator
  import vco_dec_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int CNT_W = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int SETTLE_CYC = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic        phase_in,
  output logic        vco_enb_o,
  output logic        irq_o
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  logic req, ack, we_q, en, ovf, push, pop, clear, wr, edge_p, full, empty, win_end;
  logic [7:0] off_q, irq_thr;
  logic [15:0] dat_q, win, win_len, cyc;
  logic [1:0] sel_q;
  logic [2:0] sync;
  logic [CNT_W-1:0] cnt, cnt_inc, fifo_q;
  logic [LW-1:0] level;
  logic [31:0] status, rd_mux;
  logic unused_ok;
  state_t state, state_n;
  assign unused_ok = ^{wbs_dat_i[31:16], wbs_sel_i[3:2]};
  assign req = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign wr = ack & we_q;
  assign clear = wr & (off_q == OFF_CTRL) & sel_q[0] & dat_q[1];
  assign pop = ack & ~we_q & (off_q == OFF_DATA);
  assign edge_p = sync[1] & ~sync[2];
  assign cnt_inc = (edge_p && !(&cnt)) ? cnt + 1'b1 : cnt;
  assign win_end = (state == RUN) && (cyc == win_len - 16'd1);
  assign push = win_end;
  assign state_n = !en ? IDLE : (state == IDLE) ? SETTLE :
                   (state == SETTLE && cyc == 16'(SETTLE_CYC - 1)) ? RUN : state;
  assign vco_enb_o = state != IDLE;
  assign wbs_ack_o = ack;
  assign wbs_dat_o = ack ? rd_mux : 32'd0;
  always_comb begin
    status = '0;
    status[7:0] = 8'(level);
    status[ST_OVF] = ovf;
    status[ST_EMPTY] = empty;
    status[ST_FULL] = full;
  end
  assign rd_mux = (off_q == OFF_CTRL) ? {31'd0, en} :
                  (off_q == OFF_WIN) ? {16'd0, win} :
                  (off_q == OFF_STATUS) ? status :
                  (off_q == OFF_DATA) ? (empty ? 32'd0 : {1'b1, 31'(fifo_q)}) :
                  (off_q == OFF_IRQ) ? {24'd0, irq_thr} : 32'd0;
  always_ff @(posedge wb_clk_i) begin
    if (req && !ack) begin
      we_q <= wbs_we_i;
      off_q <= wbs_adr_i[7:0];
      dat_q <= wbs_dat_i[15:0];
      sel_q <= wbs_sel_i[1:0];
    end
  end
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack <= 1'b0;
      en <= 1'b0;
      win <= WIN_RST;
      sync <= '0;
      state <= IDLE;
      cyc <= '0;
      win_len <= 16'd1;
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      ack <= req & ~ack;
      if (wr && off_q == OFF_CTRL && sel_q[0]) en <= dat_q[0];
      if (wr && off_q == OFF_WIN && sel_q[0]) win[7:0] <= dat_q[7:0];
      if (wr && off_q == OFF_WIN && sel_q[1]) win[15:8] <= dat_q[15:8];
      sync <= {sync[1:0], phase_in};
      state <= state_n;
      cyc <= (state_n != state || win_end || state == IDLE) ? 16'd0 : cyc + 16'd1;
      if ((state == SETTLE && state_n == RUN) || win_end) win_len <= win_eff(win);
      cnt <= (state != RUN || win_end) ? '0 : cnt_inc;
      ovf <= clear ? 1'b0 : (push & full & ~pop) ? 1'b1 : ovf;
    end
  end
  vco_dec_fifo #(.W(CNT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(wb_clk_i),
    .rst(wb_rst_i),
    .push(push),
    .pop(pop),
    .flush(clear),
    .wdata(cnt_inc),
    .rdata(fifo_q),
    .level(level),
    .full(full),
    .empty(empty)
  );
`ifdef VCO_DEC_IRQ_EN
  logic irq_q;
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      irq_thr <= IRQ_THR_RST;
      irq_q <= 1'b0;
    end else begin
      if (wr && off_q == OFF_IRQ && sel_q[0]) irq_thr <= dat_q[7:0];
      irq_q <= (8'(level) >= irq_thr) | ovf;
    end
  end
  assign irq_o = irq_q;
`else
  assign irq_thr = 8'd0;
  assign irq_o = 1'b0;
`endif
endmodule
